// File: rtl/dds_freq_meter.sv
// Gated-window edge counter that reports a DDS tuning word for sig_in.
// Window = 2^GATE_LOG2 clk cycles, aligned to the first synchronized rise.
module dds_freq_meter #(
    parameter int GATE_LOG2 = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sig_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 valid,
    output logic [31:0]          k_out,
    output logic [GATE_LOG2:0]   edge_cnt,
    output logic                 no_signal
);

    localparam int CW = GATE_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   s1_q, s2_q, s3_q;
    logic                   rise;
    logic [GATE_LOG2-1:0]   tmr_q, tmr_d;
    logic                   tmr_last;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          edge_q;
    logic [31:0]            k_q, k_d;
    logic                   ns_q;
    logic                   load;

    assign rise     = s2_q & ~s3_q;
    assign tmr_last = &tmr_q;

    // Two-flop synchronizer plus a history flop for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= sig_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Next-state, window timer and saturating edge counter
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q + 1'b1;
        cnt_d   = cnt_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (start) begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
            end
            ARM: begin
                if (rise) begin
                    state_d = GATE;
                    tmr_d   = '0;
                end else if (tmr_last) begin
                    state_d = DONE;
                    load    = 1'b1;
                end
            end
            GATE: begin
                if (rise && !(&cnt_q)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (tmr_last) begin
                    state_d = DONE;
                    load    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Count << (32-GATE_LOG2) keeps only the low GATE_LOG2 count bits
    assign k_d = {cnt_d[GATE_LOG2-1:0], {(32-GATE_LOG2){1'b0}}};

    // State, timer and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Results load on entry to DONE so they are visible with valid
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q <= '0;
            k_q    <= '0;
            ns_q   <= 1'b0;
        end else if (load) begin
            edge_q <= cnt_d;
            k_q    <= k_d;
            ns_q   <= (cnt_d == '0);
        end
    end

    assign busy      = (state_q == ARM) || (state_q == GATE);
    assign valid     = (state_q == DONE);
    assign k_out     = k_q;
    assign edge_cnt  = edge_q;
    assign no_signal = ns_q;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter with a 256-cycle window.
// Vectors hold sig_in period and hand-computed results.
module tb_dds_freq_meter;

    localparam int GL = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        sig_in;
    logic        start;
    logic        busy;
    logic        valid;
    logic [31:0] k_out;
    logic [GL:0] edge_cnt;
    logic        no_signal;

    int per;
    int ph;
    int pass_n = 0;
    int total_n = 0;

    typedef struct {
        int          per;
        int          extra;
        logic [GL:0] edge_e;
        logic [31:0] k_e;
        logic        ns_e;
        int          busy_e;
    } vec_t;

    vec_t tab[5];

    dds_freq_meter #(.GATE_LOG2(GL)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .start     (start),
        .busy      (busy),
        .valid     (valid),
        .k_out     (k_out),
        .edge_cnt  (edge_cnt),
        .no_signal (no_signal)
    );

    always #5 clk = ~clk;

    // Square-wave source; per==0 holds it low
    initial begin
        sig_in = 1'b0;
        ph = 0;
        per = 0;
        forever begin
            @(negedge clk);
            if (per == 0) begin
                sig_in = 1'b0;
                ph = 0;
            end else if (ph >= per / 2 - 1) begin
                sig_in = ~sig_in;
                ph = 0;
            end else begin
                ph++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic run(input vec_t v, input int id);
        logic [31:0] k_prev;
        int          got;
        int          busyc;
        int          stable;
        int          extra_v;
        per = v.per;
        repeat (100) @(negedge clk);
        k_prev = k_out;
        got = 0;
        busyc = 0;
        stable = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3000 && got == 0; c++) begin
            if (valid) begin
                got = 1;
            end else begin
                if (busy) busyc++;
                if (k_out !== k_prev) stable = 0;
            end
            start = (v.extra > 0 && got == 0 && busy && c % 4 == 1
                     && c < 4 * v.extra) ? 1'b1 : 1'b0;
            if (got == 0) @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("v%0d_valid_seen", id), 64'(got), 64'd1);
        chk($sformatf("v%0d_edge_cnt", id), 64'(edge_cnt), 64'(v.edge_e));
        chk($sformatf("v%0d_k_out", id), 64'(k_out), 64'(v.k_e));
        chk($sformatf("v%0d_no_signal", id), 64'(no_signal), 64'(v.ns_e));
        if (v.busy_e >= 0)
            chk($sformatf("v%0d_busy_cycles", id), 64'(busyc),
                64'(v.busy_e));
        k_prev = k_out;
        extra_v = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (valid) extra_v++;
            if (k_out !== k_prev) stable = 0;
        end
        chk($sformatf("v%0d_extra_valid", id), 64'(extra_v), 64'd0);
        chk($sformatf("v%0d_k_stable", id), 64'(stable), 64'd1);
    endtask

    initial begin
        int nv;
        int bz;
        tab[0] = '{16, 0, 9'd16,  32'h1000_0000, 1'b0, -1};
        tab[1] = '{2,  0, 9'd128, 32'h8000_0000, 1'b0, -1};
        tab[2] = '{0,  0, 9'd0,   32'h0000_0000, 1'b1, 256};
        tab[3] = '{16, 6, 9'd16,  32'h1000_0000, 1'b0, -1};
        tab[4] = '{32, 0, 9'd8,   32'h0800_0000, 1'b0, -1};

        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_k_out", 64'(k_out), 64'd0);
        chk("rst_edge_cnt", 64'(edge_cnt), 64'd0);
        chk("rst_no_signal", 64'(no_signal), 64'd0);

        // start together with rst must not launch a measurement
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        bz = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) bz++;
        end
        chk("rst_start_ignored", 64'(bz), 64'd0);

        for (int i = 0; i < 5; i++) run(tab[i], i);

        // Reset in the middle of GATE discards the measurement
        per = 16;
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (150) @(negedge clk);
        chk("mid_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_valid", 64'(valid), 64'd0);
        chk("mid_k_out", 64'(k_out), 64'd0);
        chk("mid_edge_cnt", 64'(edge_cnt), 64'd0);
        chk("mid_no_signal", 64'(no_signal), 64'd0);
        nv = 0;
        repeat (400) begin
            @(negedge clk);
            if (valid) nv++;
        end
        chk("mid_no_valid", 64'(nv), 64'd0);

        run(tab[0], 5);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
